// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared types and constants for the fetch stage and its branch target buffer.
//   word_t        : 32-bit machine word
//   HALT_OPCODE   : primary opcode that stops instruction fetch
//   fetch_state_t : RUN / HALTED
//   btb_entry_t   : {valid, tag, target, ctr}, one direct-mapped BTB line
// Helpers: opcode_of() extracts the primary opcode, ctr_update() steps a
// 2-bit saturating direction counter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;
  localparam logic [1:0] CTR_INIT    = 2'b01;   // weakly not-taken

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // Tag is held at full 30-bit width; only the bits above the index are
  // meaningful, the rest are always zero.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    word_t       target;
    logic [1:0]  ctr;
  } btb_entry_t;

  function automatic logic [5:0] opcode_of(input word_t instr);
    return instr[31:26];
  endfunction

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != 2'b11) res = ctr + 2'd1;
    else if (!taken && ctr != 2'b00) res = ctr - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if
// Bundles every fetch-stage signal except clk/rst.
//   icache   : ihit, imemload (in)  / imemREN, imemaddr (out)
//   hazard   : pc_en, stall_ifid, flush_ifid (in)
//   redirect : redirect_valid, redirect_pc (in)
//   BTB upd  : upd_valid, upd_pc, upd_target, upd_taken (in)
//   IF/ID    : ifid_valid, ifid_instr, ifid_pc, ifid_npc, ifid_pred_taken (out)
// Modports: master = the fetch stage itself, slave = the surrounding pipeline
// (icache, hazard unit, EX) that drives its inputs and consumes IF/ID.
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t imemload;
  logic  imemREN;
  word_t imemaddr;
  logic  pc_en;
  logic  stall_ifid;
  logic  flush_ifid;
  logic  redirect_valid;
  word_t redirect_pc;
  logic  upd_valid;
  word_t upd_pc;
  word_t upd_target;
  logic  upd_taken;
  logic  ifid_valid;
  word_t ifid_instr;
  word_t ifid_pc;
  word_t ifid_npc;
  logic  ifid_pred_taken;

  modport master (
    input  ihit, imemload, pc_en, stall_ifid, flush_ifid,
           redirect_valid, redirect_pc,
           upd_valid, upd_pc, upd_target, upd_taken,
    output imemREN, imemaddr,
           ifid_valid, ifid_instr, ifid_pc, ifid_npc, ifid_pred_taken
  );

  modport slave (
    output ihit, imemload, pc_en, stall_ifid, flush_ifid,
           redirect_valid, redirect_pc,
           upd_valid, upd_pc, upd_target, upd_taken,
    input  imemREN, imemaddr,
           ifid_valid, ifid_instr, ifid_pc, ifid_npc, ifid_pred_taken
  );

endinterface

// File: rtl/fetch_btb.sv
// fetch_btb
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset (all lines invalid)
//   lookup_pc           : PC being fetched this cycle
//   pred_taken          : hit with counter MSB set
//   pred_target         : stored target of the indexed line
//   upd_valid/pc/target/taken : resolved-branch update from EX
// Lookup is combinational from the line registers, so a same-cycle update
// at the same index is only visible from the next cycle on (old entry read).
module fetch_btb
  import cpu_types_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  word_t lookup_pc,
  output logic  pred_taken,
  output word_t pred_target,
  input  logic  upd_valid,
  input  word_t upd_pc,
  input  word_t upd_target,
  input  logic  upd_taken
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  btb_entry_t mem_reg [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [29:0]      rd_tag;
  logic [29:0]      wr_tag;
  btb_entry_t       rd_entry;
  btb_entry_t       wr_entry;
  btb_entry_t       wr_entry_next;
  logic             wr_hit;
  logic             wr_en;

  // Byte-offset bits never take part in index or tag.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign rd_idx = lookup_pc[IDX_W+1:2];
  assign rd_tag = 30'(lookup_pc >> (IDX_W + 2));
  assign wr_idx = upd_pc[IDX_W+1:2];
  assign wr_tag = 30'(upd_pc >> (IDX_W + 2));

  assign rd_entry    = mem_reg[rd_idx];
  assign pred_taken  = rd_entry.valid && (rd_entry.tag == rd_tag) && rd_entry.ctr[1];
  assign pred_target = rd_entry.target;

  always_comb begin
    wr_entry      = mem_reg[wr_idx];
    wr_hit        = wr_entry.valid && (wr_entry.tag == wr_tag);
    wr_en         = 1'b0;
    wr_entry_next = wr_entry;
    if (upd_valid) begin
      if (wr_hit) begin
        wr_en                = 1'b1;
        wr_entry_next.target = upd_target;
        wr_entry_next.ctr    = ctr_update(wr_entry.ctr, upd_taken);
      end else if (upd_taken) begin
        // Only taken branches earn a line; not-taken misses would just
        // evict something useful.
        wr_en         = 1'b1;
        wr_entry_next = '{valid: 1'b1, tag: wr_tag, target: upd_target, ctr: CTR_INIT};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        mem_reg[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_INIT};
      end
    end else if (wr_en) begin
      mem_reg[wr_idx] <= wr_entry_next;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// IF stage of the 5-stage pipeline: owns the PC, drives the icache request,
// fills the IF/ID latch, follows hazard-unit controls, accepts downstream
// redirects and stops fetching once a HALT reaches IF/ID.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : fetch_stage_if.master (icache, hazard, redirect, BTB update, IF/ID)
// Parameters:
//   PC_INIT     : PC loaded on reset
//   BTB_ENTRIES : BTB depth, power of 2, >= 2 (only with FETCH_BTB_EN)
// Build option: define FETCH_BTB_EN to add the fetch_btb predictor; without
// it the next sequential PC is always predicted and ifid_pred_taken is 0.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT     = 32'h0,
  parameter int    BTB_ENTRIES = 16
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.master bus
);

  fetch_state_t state_reg, state_next;
  word_t        pc_reg, pc_next;
  logic         pend_valid_reg, pend_valid_next;
  word_t        pend_pc_reg, pend_pc_next;

  logic  ifid_valid_reg, ifid_valid_next;
  word_t ifid_instr_reg, ifid_instr_next;
  word_t ifid_pc_reg, ifid_pc_next;
  word_t ifid_npc_reg, ifid_npc_next;
  logic  ifid_pred_reg, ifid_pred_next;

  logic  pred_taken;
  word_t pred_target;
  word_t pc_plus4;
  logic  squash;
  logic  capture;
  logic  ifid_load;

`ifdef FETCH_BTB_EN
  fetch_btb #(
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc   (pc_reg),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (bus.upd_valid),
    .upd_pc      (bus.upd_pc),
    .upd_target  (bus.upd_target),
    .upd_taken   (bus.upd_taken)
  );
`else
  assign pred_taken  = 1'b0;
  assign pred_target = '0;

  logic unused_upd;
  assign unused_upd = ^{bus.upd_valid, bus.upd_pc, bus.upd_target, bus.upd_taken};
`endif

  assign pc_plus4 = pc_reg + 32'd4;   // wraps modulo 2^32

  // The word returned in a redirect cycle, or while a redirect is still
  // waiting for pc_en, belongs to the wrong path.
  assign squash    = bus.redirect_valid | pend_valid_reg;
  assign capture   = bus.ihit && (state_reg == RUN) && !squash;
  assign ifid_load = capture && !bus.flush_ifid && !bus.stall_ifid;

  // PC / state / pending-redirect next-state logic
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    pend_valid_next = pend_valid_reg;
    pend_pc_next    = pend_pc_reg;

    case (state_reg)
      RUN: begin
        if (bus.pc_en) begin
          pend_valid_next = 1'b0;
          if (bus.redirect_valid)  pc_next = bus.redirect_pc;
          else if (pend_valid_reg) pc_next = pend_pc_reg;
          else if (pred_taken)     pc_next = pred_target;
          else                     pc_next = pc_plus4;
        end else if (bus.redirect_valid) begin
          // Request still outstanding: remember the target until PC may move.
          pend_valid_next = 1'b1;
          pend_pc_next    = bus.redirect_pc;
        end
        if (ifid_load && opcode_of(bus.imemload) == HALT_OPCODE) begin
          state_next = HALTED;
        end
      end
      HALTED: begin
        // No request is outstanding here, so a redirect loads PC directly.
        if (bus.redirect_valid) begin
          state_next      = RUN;
          pc_next         = bus.redirect_pc;
          pend_valid_next = 1'b0;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // IF/ID next-state: flush > stall > capture > bubble
  always_comb begin
    ifid_valid_next = 1'b0;
    ifid_instr_next = '0;
    ifid_pc_next    = '0;
    ifid_npc_next   = '0;
    ifid_pred_next  = 1'b0;
    if (bus.flush_ifid) begin
      ifid_valid_next = 1'b0;
    end else if (bus.stall_ifid) begin
      ifid_valid_next = ifid_valid_reg;
      ifid_instr_next = ifid_instr_reg;
      ifid_pc_next    = ifid_pc_reg;
      ifid_npc_next   = ifid_npc_reg;
      ifid_pred_next  = ifid_pred_reg;
    end else if (capture) begin
      ifid_valid_next = 1'b1;
      ifid_instr_next = bus.imemload;
      ifid_pc_next    = pc_reg;
      ifid_npc_next   = pc_plus4;
      ifid_pred_next  = pred_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= RUN;
      pc_reg         <= PC_INIT;
      pend_valid_reg <= 1'b0;
      pend_pc_reg    <= '0;
      ifid_valid_reg <= 1'b0;
      ifid_instr_reg <= '0;
      ifid_pc_reg    <= '0;
      ifid_npc_reg   <= '0;
      ifid_pred_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      pend_valid_reg <= pend_valid_next;
      pend_pc_reg    <= pend_pc_next;
      ifid_valid_reg <= ifid_valid_next;
      ifid_instr_reg <= ifid_instr_next;
      ifid_pc_reg    <= ifid_pc_next;
      ifid_npc_reg   <= ifid_npc_next;
      ifid_pred_reg  <= ifid_pred_next;
    end
  end

  assign bus.imemREN         = (state_reg == RUN);
  assign bus.imemaddr        = pc_reg;
  assign bus.ifid_valid      = ifid_valid_reg;
  assign bus.ifid_instr      = ifid_instr_reg;
  assign bus.ifid_pc         = ifid_pc_reg;
  assign bus.ifid_npc        = ifid_npc_reg;
  assign bus.ifid_pred_taken = ifid_pred_reg;

endmodule
